// File: rtl/sam_mul_arbiter_pkg.sv
// Shared constants, tag type and round-robin pick helper for the
// multiplier-sharing arbiter.
package sam_arb_pkg;

   localparam int NREQ = 4;
   localparam int W    = 32;
   localparam int LAT  = 2;
   localparam int ID_W = $clog2(NREQ);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } sam_tag_t;

   typedef struct packed {
      logic            found;
      logic [ID_W-1:0] id;
   } rr_pick_t;

   // Scan the request vector starting at ptr and wrapping around; the
   // first asserted requester found is the winner.
   function automatic rr_pick_t rr_pick(input logic [NREQ-1:0] req,
                                        input logic [ID_W-1:0] ptr);
      rr_pick_t        r;
      logic [ID_W-1:0] idx;
      r.found = 1'b0;
      r.id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % NREQ);
         if (!r.found && req[idx]) begin
            r.found = 1'b1;
            r.id    = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sam_mul_arbiter_if.sv
// Requester-side bus of the shared multiplier: operand requests in,
// one-hot grants and tagged results out.
interface sam_mul_arbiter_if #(
   parameter int NREQ = sam_arb_pkg::NREQ,
   parameter int W    = sam_arb_pkg::W
);

   logic              hold;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   resp_valid;
   logic [2*W-1:0]    resp_result;
   logic              busy;

   modport master (
      output hold, req_valid, req_a, req_b,
      input  req_ready, resp_valid, resp_result, busy
   );

   modport slave (
      input  hold, req_valid, req_a, req_b,
      output req_ready, resp_valid, resp_result, busy
   );

endinterface

// File: rtl/sam_mul_arbiter_mul_pipe.sv
// LAT-stage unsigned W x W multiplier: operand register, combinational
// core, then LAT-1 product registers. The operand register only loads on
// an accepted request, so the product holds while no new work arrives.
module sam_mul_pipe #(
   parameter int W   = 32,
   parameter int LAT = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] product
);

   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [2*W-1:0] core;
   logic [2*W-1:0] prod_q [LAT-1];

   // Capture the granted operand pair at the end of the accept cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else if (load) begin
         a_q <= a;
         b_q <= b;
      end
   end

   // Full-width unsigned product; operands are zero-extended so nothing truncates.
   always_comb begin
      core = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
   end

   // Product register chain that brings the total depth up to LAT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LAT - 1; i++) prod_q[i] <= '0;
      end else begin
         prod_q[0] <= core;
         for (int i = 1; i < LAT - 1; i++) prod_q[i] <= prod_q[i-1];
      end
   end

   assign product = prod_q[LAT-2];

endmodule

// File: rtl/sam_mul_arbiter.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ
// requesters. A requester tag rides alongside each operation through a
// pipeline as deep as the multiplier, so each product is steered back to
// the requester that issued it. Tag ids are sized by the package NREQ.
module sam_mul_arbiter
   import sam_arb_pkg::*;
#(
   parameter int NREQ = sam_arb_pkg::NREQ,
   parameter int W    = sam_arb_pkg::W,
   parameter int LAT  = sam_arb_pkg::LAT
) (
   input  logic            clk,
   input  logic            reset,
   sam_mul_arbiter_if.slave bus
);

   rr_pick_t        pick;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] win_id;
   logic            accept;
   logic [NREQ-1:0] ready;
   logic [W-1:0]    win_a;
   logic [W-1:0]    win_b;
   sam_tag_t        tag_q [LAT];
   logic [NREQ-1:0] resp_valid;
   logic            busy;

   // Pick a winner starting at rr_ptr; grant only when not held and not in reset.
   always_comb begin
      pick   = rr_pick(bus.req_valid, rr_ptr);
      win_id = pick.id;
      accept = pick.found & ~bus.hold & ~reset;
      ready  = '0;
      if (accept) ready[win_id] = 1'b1;
      win_a  = bus.req_a[int'(win_id)*W +: W];
      win_b  = bus.req_b[int'(win_id)*W +: W];
   end

   assign bus.req_ready = ready;

   // Advance the pointer past the winner so it gets lowest priority next time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
      end
   end

   // Tag pipeline shifts every cycle; idle cycles inject a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0].valid <= accept;
         tag_q[0].id    <= accept ? win_id : '0;
         for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Decode the output-stage tag into the one-hot strobe and derive busy.
   always_comb begin
      resp_valid = '0;
      if (tag_q[LAT-1].valid) resp_valid[tag_q[LAT-1].id] = 1'b1;
      busy = 1'b0;
      for (int i = 0; i < LAT; i++) busy = busy | tag_q[i].valid;
   end

   assign bus.resp_valid = resp_valid;
   assign bus.busy       = busy;

   sam_mul_pipe #(
      .W   (W),
      .LAT (LAT)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .a       (win_a),
      .b       (win_b),
      .product (bus.resp_result)
   );

endmodule

// File: tb/tb_sam_mul_arbiter.sv
// Directed bench for sam_mul_arbiter: grants are checked per cycle while
// expected responses go into a scoreboard that a separate monitor drains.
module tb_sam_mul_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 32;
   localparam int LAT  = 2;

   typedef struct {
      int              due;
      logic [NREQ-1:0] onehot;
      logic [2*W-1:0]  prod;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   sam_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   sam_mul_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock and cycle counter.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic setOps(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.req_a[i*W +: W] = a;
      bus.req_b[i*W +: W] = b;
   endtask

   // One cycle: drive inputs, check the grant (and busy when exp_busy >= 0)
   // at the falling edge, and queue the hand-computed response if a grant is expected.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic h,
                                input logic [NREQ-1:0] exp_ready,
                                input logic [2*W-1:0] exp_prod, input int exp_busy);
      bus.req_valid = v;
      bus.hold      = h;
      @(negedge clk);
      checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      if (exp_busy >= 0) checkOutput("busy", 64'(bus.busy), 64'(exp_busy));
      if (exp_ready != '0) sb.push_back('{due: cyc + LAT, onehot: exp_ready, prod: exp_prod});
      @(posedge clk);
      #1;
   endtask

   // Hold reset for one cycle with the given valids and check every output is zero.
   task automatic doReset(input logic [NREQ-1:0] v);
      reset = 1'b1;
      sb.delete();
      bus.req_valid = v;
      bus.hold      = 1'b0;
      #1;
      @(negedge clk);
      checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      checkOutput("rst_resp_result", bus.resp_result, 64'd0);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Scoreboard monitor: a due entry must match this cycle, anything else is unexpected.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         checkOutput("resp_valid", 64'(bus.resp_valid), 64'(e.onehot));
         checkOutput("resp_result", bus.resp_result, e.prod);
      end else if (bus.resp_valid != '0) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL unexpected_resp at cycle %0d: got resp_valid %b, expected 0000",
                  cyc, bus.resp_valid);
      end
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cyc           = 0;
      n_tests       = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.hold      = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      doReset('1);

      // Single requester 2 back to back, including the widest product.
      setOps(2, 32'd3, 32'd5);
      applyStimulus(4'b0100, 1'b0, 4'b0100, 64'd15, 0);
      setOps(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus(4'b0100, 1'b0, 4'b0100, 64'hFFFF_FFFE_0000_0001, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 0);

      // All requesters valid: rotation 0,1,2,3,0 with A=i+1, B=10.
      doReset('0);
      for (int i = 0; i < NREQ; i++) setOps(i, W'(i + 1), 32'd10);
      applyStimulus(4'b1111, 1'b0, 4'b0001, 64'd10, -1);
      applyStimulus(4'b1111, 1'b0, 4'b0010, 64'd20, -1);
      applyStimulus(4'b1111, 1'b0, 4'b0100, 64'd30, -1);
      applyStimulus(4'b1111, 1'b0, 4'b1000, 64'd40, -1);
      applyStimulus(4'b1111, 1'b0, 4'b0001, 64'd10, -1);

      // Grant requester 1, hold three cycles, then requester 2 resumes.
      applyStimulus(4'b1111, 1'b0, 4'b0010, 64'd20, -1);
      applyStimulus(4'b1111, 1'b1, 4'b0000, 64'd0, 1);
      applyStimulus(4'b1111, 1'b1, 4'b0000, 64'd0, 1);
      applyStimulus(4'b1111, 1'b1, 4'b0000, 64'd0, 0);
      applyStimulus(4'b1111, 1'b0, 4'b0100, 64'd30, 0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 0);

      // Requester 0 withdraws while requester 3 (pointer at 3) is granted.
      applyStimulus(4'b1001, 1'b0, 4'b1000, 64'd40, 0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 0);

      // Two accepts, then reset discards them; pointer restarts at 0.
      setOps(0, 32'd7, 32'd6);
      setOps(1, 32'd9, 32'd9);
      applyStimulus(4'b0001, 1'b0, 4'b0001, 64'd42, 0);
      applyStimulus(4'b0010, 1'b0, 4'b0010, 64'd81, 1);
      doReset('1);
      applyStimulus(4'b1111, 1'b0, 4'b0001, 64'd42, 0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 0);

      // Zero operand and busy window.
      setOps(0, 32'd0, 32'h1234_5678);
      applyStimulus(4'b0001, 1'b0, 4'b0001, 64'd0, 0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 1);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 0);
      applyStimulus(4'b0000, 1'b0, 4'b0000, 64'd0, 0);

      checkOutput("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
